// File: rtl/mmc3_scanline_irq.sv
// MMC3-family scanline IRQ: A12 low-time filter, 8-bit reloading down-counter and IRQ enable/ack.
// Define MMC3_ALT_IRQ_EN for Rev A behaviour (no re-fire on an automatic reload of a zero latch).
module mmc3_scanline_irq #(
    parameter int A12_LOW_CYCLES = 3,
    parameter int COUNTER_WIDTH  = 8
) (
    input  logic                     m2,
    input  logic                     rst_n,
    input  logic                     enabled,
    input  logic                     romsel,
    input  logic                     cpu_rw_in,
    input  logic [14:0]              cpu_addr_in,
    input  logic [7:0]               cpu_data_in,
    input  logic                     ppu_a12,
    output logic                     irq_n,
    output logic [COUNTER_WIDTH-1:0] counter_dbg
);
    localparam int W = COUNTER_WIDTH;
    localparam logic [2:0]   LOW_THRESH = 3'(A12_LOW_CYCLES);
    localparam logic [W-1:0] ZERO       = {W{1'b0}};
    localparam logic [W-1:0] ONE        = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] latch_r, counter_r;
    logic         reload_r, irq_en_r, irq_pend_r;
    logic [2:0]   low_cnt_r;

    logic [W-1:0] latch_s, counter_s;
    logic         reload_s, irq_en_s, irq_pend_s, set_s;
    logic [2:0]   low_cnt_s;
    logic         wr_s, wr_c000_s, wr_c001_s, wr_e000_s, wr_e001_s, clk_evt_s;

    // Next-state logic: register decode, A12 filter, counter and IRQ set/ack priority
    always_comb begin
        wr_s      = enabled & ~romsel & ~cpu_rw_in;
        wr_c000_s = 1'b0;
        wr_c001_s = 1'b0;
        wr_e000_s = 1'b0;
        wr_e001_s = 1'b0;
        case ({cpu_addr_in[14:13], cpu_addr_in[0]})
            3'b100:  wr_c000_s = wr_s;
            3'b101:  wr_c001_s = wr_s;
            3'b110:  wr_e000_s = wr_s;
            3'b111:  wr_e001_s = wr_s;
            default: wr_c000_s = 1'b0;
        endcase

        clk_evt_s = ppu_a12 & (low_cnt_r >= LOW_THRESH);
        if (ppu_a12) begin
            low_cnt_s = 3'd0;
        end else if (low_cnt_r == 3'd7) begin
            low_cnt_s = 3'd7;
        end else begin
            low_cnt_s = low_cnt_r + 3'd1;
        end

        latch_s = wr_c000_s ? cpu_data_in[W-1:0] : latch_r;

        // A $C001 landing on the same edge as a counter clock behaves as a pending reload
        if (clk_evt_s) begin
            if ((counter_r == ZERO) || reload_r || wr_c001_s) begin
                counter_s = latch_r;
            end else begin
                counter_s = counter_r - ONE;
            end
            reload_s = 1'b0;
        end else if (wr_c001_s) begin
            counter_s = ZERO;
            reload_s  = 1'b1;
        end else begin
            counter_s = counter_r;
            reload_s  = reload_r;
        end

        if (wr_e001_s) begin
            irq_en_s = 1'b1;
        end else if (wr_e000_s) begin
            irq_en_s = 1'b0;
        end else begin
            irq_en_s = irq_en_r;
        end

`ifdef MMC3_ALT_IRQ_EN
        set_s = clk_evt_s & (counter_s == ZERO) & irq_en_s &
                ((counter_r != ZERO) | reload_r | wr_c001_s);
`else
        set_s = clk_evt_s & (counter_s == ZERO) & irq_en_s;
`endif

        if (wr_e000_s) begin
            irq_pend_s = 1'b0;
        end else if (set_s) begin
            irq_pend_s = 1'b1;
        end else begin
            irq_pend_s = irq_pend_r;
        end
    end

    // State registers
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            latch_r    <= ZERO;
            counter_r  <= ZERO;
            reload_r   <= 1'b0;
            irq_en_r   <= 1'b0;
            irq_pend_r <= 1'b0;
            low_cnt_r  <= 3'd0;
        end else begin
            latch_r    <= latch_s;
            counter_r  <= counter_s;
            reload_r   <= reload_s;
            irq_en_r   <= irq_en_s;
            irq_pend_r <= irq_pend_s;
            low_cnt_r  <= low_cnt_s;
        end
    end

    assign irq_n       = ~(irq_pend_r & enabled);
    assign counter_dbg = counter_r;
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq; expected values are hand-derived per step.
module tb_mmc3_scanline_irq;
    logic        m2 = 1'b0;
    logic        rst_n, enabled, romsel, cpu_rw_in, ppu_a12;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        irq_n;
    logic [7:0]  counter_dbg;
    int          n_vec = 0;
    int          n_err = 0;

    mmc3_scanline_irq #(.A12_LOW_CYCLES(3), .COUNTER_WIDTH(8)) dut (
        .m2(m2), .rst_n(rst_n), .enabled(enabled), .romsel(romsel),
        .cpu_rw_in(cpu_rw_in), .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .ppu_a12(ppu_a12), .irq_n(irq_n), .counter_dbg(counter_dbg)
    );

    always #5 m2 = ~m2;

    task automatic tick();
        @(posedge m2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        romsel      = 1'b0;
        cpu_rw_in   = 1'b0;
        cpu_addr_in = addr[14:0];
        cpu_data_in = data;
        tick();
        romsel    = 1'b1;
        cpu_rw_in = 1'b1;
    endtask

    // nlow samples of A12 low, then one rising sample; A12 idles high
    task automatic pulse(input int nlow);
        ppu_a12 = 1'b0;
        repeat (nlow) tick();
        ppu_a12 = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; enabled = 1'b1; romsel = 1'b1; cpu_rw_in = 1'b1;
        cpu_addr_in = 15'h0000; cpu_data_in = 8'h00; ppu_a12 = 1'b1;
        repeat (2) tick();
        chk("rst_cnt", counter_dbg, 8'd0);
        chk("rst_irq", {7'd0, irq_n}, 8'd1);
        rst_n = 1'b1;
        tick();

        // Basic countdown 3,2,1,0 and acknowledge
        wr(16'hC000, 8'd3); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
        pulse(4); chk("cd_3", counter_dbg, 8'd3); chk("cd_3_irq", {7'd0, irq_n}, 8'd1);
        pulse(4); chk("cd_2", counter_dbg, 8'd2);
        pulse(4); chk("cd_1", counter_dbg, 8'd1); chk("cd_1_irq", {7'd0, irq_n}, 8'd1);
        pulse(4); chk("cd_0", counter_dbg, 8'd0); chk("cd_0_irq", {7'd0, irq_n}, 8'd0);
        repeat (2) tick();
        chk("irq_hold", {7'd0, irq_n}, 8'd0);
        wr(16'hE000, 8'd0);
        chk("ack_irq", {7'd0, irq_n}, 8'd1);

        // Filter: 2 low samples rejected, exactly 3 accepted
        pulse(2); pulse(2);
        chk("flt_cnt", counter_dbg, 8'd0);
        chk("flt_irq", {7'd0, irq_n}, 8'd1);
        pulse(3);
        chk("flt_edge", counter_dbg, 8'd3);

        // Latch of zero
        wr(16'hC000, 8'd0); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
        pulse(4);
        chk("z0_cnt", counter_dbg, 8'd0);
        chk("z0_irq", {7'd0, irq_n}, 8'd0);
        wr(16'hE000, 8'd0); wr(16'hE001, 8'd0);
        chk("z_ack", {7'd0, irq_n}, 8'd1);
        pulse(4);
`ifdef MMC3_ALT_IRQ_EN
        chk("z1_irq", {7'd0, irq_n}, 8'd1);
`else
        chk("z1_irq", {7'd0, irq_n}, 8'd0);
`endif
        wr(16'hE000, 8'd0); wr(16'hE001, 8'd0);
        pulse(4);
`ifdef MMC3_ALT_IRQ_EN
        chk("z2_irq", {7'd0, irq_n}, 8'd1);
`else
        chk("z2_irq", {7'd0, irq_n}, 8'd0);
`endif
        wr(16'hE000, 8'd0);

        // $E000 on the same edge the counter reaches 0
        wr(16'hC000, 8'd1); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
        pulse(4);
        chk("sim_1", counter_dbg, 8'd1);
        ppu_a12 = 1'b0;
        repeat (4) tick();
        ppu_a12 = 1'b1;
        wr(16'hE000, 8'd0);
        chk("sim_cnt", counter_dbg, 8'd0);
        chk("sim_irq", {7'd0, irq_n}, 8'd1);
        wr(16'hE001, 8'd0);
        chk("sim_pend", {7'd0, irq_n}, 8'd1);

        // enabled=0: counting continues, writes ignored, irq masked
        enabled = 1'b0;
        wr(16'hC000, 8'd9);
        pulse(4); chk("dis_1", counter_dbg, 8'd1);
        pulse(4); chk("dis_0", counter_dbg, 8'd0);
        chk("dis_irq", {7'd0, irq_n}, 8'd1);
        wr(16'hE000, 8'd0);
        enabled = 1'b1;
        tick();
        chk("en_irq", {7'd0, irq_n}, 8'd0);
        wr(16'hE000, 8'd0); wr(16'hE001, 8'd0);
        pulse(4); chk("en_latch", counter_dbg, 8'd1);
        pulse(4); chk("en_irq2", {7'd0, irq_n}, 8'd0);

        // Reset mid-count with counter=5 and irq asserted
        wr(16'hC000, 8'd5); wr(16'hC001, 8'd0);
        pulse(4);
        chk("pre_cnt", counter_dbg, 8'd5);
        chk("pre_irq", {7'd0, irq_n}, 8'd0);
        ppu_a12 = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("ar_cnt", counter_dbg, 8'd0);
        chk("ar_irq", {7'd0, irq_n}, 8'd1);
        #2 rst_n = 1'b1;
        ppu_a12 = 1'b1;
        tick();
        wr(16'hC000, 8'd1); wr(16'hC001, 8'd0);
        pulse(4); chk("pr_1", counter_dbg, 8'd1);
        pulse(4); chk("pr_0", counter_dbg, 8'd0);
        chk("pr_noirq", {7'd0, irq_n}, 8'd1);
        wr(16'hE001, 8'd0); wr(16'hC001, 8'd0);
        pulse(4); pulse(4);
        chk("pr_irq", {7'd0, irq_n}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
